// File: rtl/semaforo_planificador.sv
// Two-street traffic light phase scheduler: green -> yellow -> all-red -> opposite green,
// with min/max green timing, demand sensing and an emergency all-red hold.
module semaforo_planificador #(
   parameter int CW          = 8,
   parameter int T_VERDE_MIN = 4,
   parameter int T_VERDE_MAX = 12,
   parameter int T_AMARILLO  = 2,
   parameter int T_TODO_ROJO = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       TA,
   input  logic       TB,
   input  logic       E,
   output logic [1:0] verde,
   output logic [1:0] amarillo,
   output logic [1:0] rojo,
   output logic [2:0] estado,
   output logic       cambio
);

   typedef enum logic [2:0] {
      VA    = 3'd0,
      AA    = 3'd1,
      RR_AB = 3'd2,
      VB    = 3'd3,
      AB    = 3'd4,
      RR_BA = 3'd5,
      EMERG = 3'd6
   } state_t;

   // Thresholds are the last cnt value of a phase, so a T-cycle phase ends at T-1.
   localparam logic [CW-1:0] CNT_SAT  = '1;
   localparam logic [CW-1:0] VMIN_END = CW'(T_VERDE_MIN - 1);
   localparam logic [CW-1:0] VMAX_END = CW'(T_VERDE_MAX - 1);
   localparam logic [CW-1:0] AM_END   = CW'(T_AMARILLO - 1);
   localparam logic [CW-1:0] RR_END   = CW'(T_TODO_ROJO - 1);

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          salto;

   assign salto = (state_nx != state);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= VA;
         cnt    <= '0;
         cambio <= 1'b0;
      end else begin
         state  <= state_nx;
         cambio <= salto;
         if (salto)
            cnt <= '0;
         else if (cnt != CNT_SAT)
            cnt <= cnt + CW'(1);
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         VA: begin
            if (E || (TB && !TA && cnt >= VMIN_END) || (TB && cnt >= VMAX_END))
               state_nx = AA;
         end
         AA: begin
            if (cnt == AM_END)
               state_nx = RR_AB;
         end
         RR_AB: begin
            if (cnt == RR_END)
               state_nx = E ? EMERG : VB;
         end
         VB: begin
            if (E || (TA && !TB && cnt >= VMIN_END) || (TA && cnt >= VMAX_END))
               state_nx = AB;
         end
         AB: begin
            if (cnt == AM_END)
               state_nx = RR_BA;
         end
         RR_BA: begin
            if (cnt == RR_END)
               state_nx = E ? EMERG : VA;
         end
         EMERG: begin
            // A wins a tie or an idle intersection when the emergency clears.
            if (!E)
               state_nx = (TB && !TA) ? VB : VA;
         end
         default: state_nx = VA;
      endcase
   end

   always_comb begin
      verde    = 2'b00;
      amarillo = 2'b00;
      rojo     = 2'b11;
      case (state)
         VA: begin
            verde = 2'b01;
            rojo  = 2'b10;
         end
         AA: begin
            amarillo = 2'b01;
            rojo     = 2'b10;
         end
         VB: begin
            verde = 2'b10;
            rojo  = 2'b01;
         end
         AB: begin
            amarillo = 2'b10;
            rojo     = 2'b01;
         end
         default: rojo = 2'b11;
      endcase
   end

   assign estado = state;

endmodule

// File: tb/tb_semaforo_planificador.sv
// Randomized and directed bench for semaforo_planificador against a phase-level model
// (street owning right of way, phase kind, elapsed time).
module tb_semaforo_planificador;

   localparam int T_MIN = 4;
   localparam int T_MAX = 12;
   localparam int T_AM  = 2;
   localparam int T_RR  = 1;
   localparam logic [9:0] RST_VEC = {2'b01, 2'b00, 2'b10, 3'd0, 1'b0};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       TA = 1'b0, TB = 1'b0, E = 1'b0;
   logic [1:0] verde, amarillo, rojo;
   logic [2:0] estado;
   logic       cambio;
   logic [9:0] dv;

   int passed = 0;
   int total  = 0;

   // Model: kind 0=green 1=yellow 2=all-red 3=emergency; st = street owning the phase.
   int m_kind, m_st, m_t;
   bit m_new;

   semaforo_planificador dut (
      .clk(clk), .reset(reset), .TA(TA), .TB(TB), .E(E),
      .verde(verde), .amarillo(amarillo), .rojo(rojo),
      .estado(estado), .cambio(cambio)
   );

   always #5 clk = ~clk;

   assign dv = {verde, amarillo, rojo, estado, cambio};

   function automatic void model_reset();
      m_kind = 0; m_st = 0; m_t = 0; m_new = 1'b0;
   endfunction

   function automatic void model_step(bit ta, bit tb, bit e);
      bit mine, other, leave;
      int nk, ns;
      mine  = m_st ? tb : ta;
      other = m_st ? ta : tb;
      leave = 1'b0; nk = m_kind; ns = m_st;
      case (m_kind)
         0: if (e || (other && !mine && m_t + 1 >= T_MIN) || (other && m_t + 1 >= T_MAX)) begin
               leave = 1'b1; nk = 1;
            end
         1: if (m_t + 1 == T_AM) begin leave = 1'b1; nk = 2; end
         2: if (m_t + 1 == T_RR) begin
               leave = 1'b1;
               nk = e ? 3 : 0;
               ns = e ? m_st : 1 - m_st;
            end
         default: if (!e) begin
               leave = 1'b1; nk = 0; ns = (tb && !ta) ? 1 : 0;
            end
      endcase
      m_kind = nk; m_st = ns;
      m_t = leave ? 0 : m_t + 1;
      m_new = leave;
   endfunction

   function automatic logic [9:0] model_vec();
      logic [1:0] lit, v, a, r;
      logic [2:0] est;
      lit = (m_st != 0) ? 2'b10 : 2'b01;
      v = 2'b00; a = 2'b00; r = 2'b11;
      if (m_kind == 0) begin v = lit; r = ~lit; end
      else if (m_kind == 1) begin a = lit; r = ~lit; end
      est = (m_kind == 3) ? 3'd6 : 3'(m_st * 3 + m_kind);
      return {v, a, r, est, m_new};
   endfunction

   // Called at a falling edge: apply inputs, let one rising edge pass, return at next falling edge.
   task automatic step(input logic ta, input logic tb, input logic e);
      TA = ta; TB = tb; E = e;
      @(posedge clk);
      model_step(ta, tb, e);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; TA = 1'b0; TB = 1'b1; E = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (dv !== RST_VEC) $display("FAIL reset_hold c%0d: got %b want %b", i, dv, RST_VEC);
         else passed++;
      end
      model_reset();
      reset = 1'b1;
   endtask

   task automatic test_b_demand();
      logic [2:0] est_tab [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
      for (int i = 0; i < 10; i++) begin
         total++;
         if (dv !== model_vec()) $display("FAIL b_demand c%0d: got %b want %b", i, dv, model_vec());
         else passed++;
         total++;
         if (estado !== est_tab[i]) $display("FAIL b_demand_seq c%0d: got %0d want %0d", i, estado, est_tab[i]);
         else passed++;
         step(1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_both_demand();
      logic [2:0] est [60];
      logic [2:0] prev;
      int run_a, run_b, i;
      do_reset();
      prev = 3'd0;
      for (int k = 0; k < 60; k++) begin
         total++;
         if (dv !== model_vec()) $display("FAIL both c%0d: got %b want %b", k, dv, model_vec());
         else passed++;
         if (k > 0) begin
            total++;
            if (cambio !== (estado != prev)) $display("FAIL both_cambio c%0d: got %b want %b", k, cambio, estado != prev);
            else passed++;
         end
         est[k] = estado;
         prev = estado;
         step(1'b1, 1'b1, 1'b0);
      end
      run_a = 0;
      while (run_a < 60 && est[run_a] == 3'd0) run_a++;
      i = run_a;
      while (i < 60 && est[i] != 3'd3) i++;
      run_b = 0;
      while (i < 60 && est[i] == 3'd3) begin run_b++; i++; end
      total++;
      if (run_a != 12) $display("FAIL both_green_a: got %0d want 12", run_a);
      else passed++;
      total++;
      if (run_b != 12) $display("FAIL both_green_b: got %0d want 12", run_b);
      else passed++;
   endtask

   task automatic test_hold_a();
      do_reset();
      // 257 cycles would wrap an 8-bit count back to 1; a saturating count still allows the exit.
      for (int k = 0; k < 257; k++) begin
         total++;
         if (dv !== model_vec()) $display("FAIL hold_a c%0d: got %b want %b", k, dv, model_vec());
         else passed++;
         step(1'b1, 1'b0, 1'b0);
      end
      step(1'b0, 1'b1, 1'b0);
      total++;
      if (estado !== 3'd1 || dv !== model_vec())
         $display("FAIL hold_a_exit: got %b want %b", dv, model_vec());
      else passed++;
   endtask

   task automatic test_emergency();
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b0, 1'b1);
         total++;
         if (dv !== model_vec()) $display("FAIL emerg c%0d: got %b want %b", k, dv, model_vec());
         else passed++;
      end
      total++;
      if (estado !== 3'd6 || rojo !== 2'b11) $display("FAIL emerg_hold: got est %0d rojo %b want 6 11", estado, rojo);
      else passed++;
      step(1'b0, 1'b1, 1'b0);
      total++;
      if (estado !== 3'd3 || verde !== 2'b10 || cambio !== 1'b1)
         $display("FAIL emerg_exit: got est %0d verde %b cambio %b want 3 10 1", estado, verde, cambio);
      else passed++;
   endtask

   task automatic reach_yellow_b(output bit ok);
      int guard;
      guard = 0;
      while (!(m_kind == 1 && m_st == 1) && guard < 40) begin
         if (m_kind == 0 && m_st == 0) step(1'b0, 1'b1, 1'b0);
         else step(1'b1, 1'b0, 1'b0);
         guard++;
      end
      ok = (m_kind == 1 && m_st == 1);
   endtask

   task automatic test_e_in_yellow();
      bit ok, saw_emerg;
      do_reset();
      reach_yellow_b(ok);
      total++;
      if (!ok || estado !== 3'd4) $display("FAIL yellow_reach: got est %0d want 4", estado);
      else passed++;
      saw_emerg = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, k == 0);
         if (estado == 3'd6) saw_emerg = 1'b1;
         total++;
         if (dv !== model_vec()) $display("FAIL yellow_e c%0d: got %b want %b", k, dv, model_vec());
         else passed++;
      end
      total++;
      if (saw_emerg || estado !== 3'd0) $display("FAIL yellow_e_end: got est %0d emerg %b want 0 0", estado, saw_emerg);
      else passed++;
   endtask

   task automatic test_async_reset();
      bit ok;
      do_reset();
      reach_yellow_b(ok);
      total++;
      if (!ok || amarillo !== 2'b10) $display("FAIL async_reach: got amarillo %b want 10", amarillo);
      else passed++;
      #2 reset = 1'b0;
      #1;
      total++;
      if (dv !== RST_VEC) $display("FAIL async_immediate: got %b want %b", dv, RST_VEC);
      else passed++;
      @(negedge clk);
      model_reset();
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         total++;
         if (dv !== model_vec()) $display("FAIL async_restart c%0d: got %b want %b", k, dv, model_vec());
         else passed++;
         step(1'b0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_random();
      logic ta, tb, e;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         total++;
         if (dv !== model_vec()) $display("FAIL random c%0d: got %b want %b", k, dv, model_vec());
         else passed++;
         ta = 1'($urandom_range(0, 1));
         tb = 1'($urandom_range(0, 1));
         e  = ($urandom_range(0, 9) == 0);
         step(ta, tb, e);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_b_demand();
      test_both_demand();
      test_hold_a();
      test_emergency();
      test_e_in_yellow();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
